// File: rtl/pi_control_mul_pkg.sv
// Shared constants and the round-half-up / saturate helper for the PI
// control multiplier.
// Contents: default widths, PROD_WIDTH, DOUT_MAX/DOUT_MIN for the default
// result width, round_sat_t and round_sat().
// Optional feature macro used by the datapath: PI_CONTROL_MUL_ACC_EN.
package pi_control_mul_pkg;

  localparam int unsigned DEF_DIN0_WIDTH = 16;
  localparam int unsigned DEF_DIN1_WIDTH = 17;
  localparam int unsigned DEF_DOUT_WIDTH = 16;

  // Full signed product width for the default operand widths.
  localparam int unsigned PROD_WIDTH = DEF_DIN0_WIDTH + DEF_DIN1_WIDTH;

  // Saturation limits of the default result width.
  localparam int DOUT_MAX = (2 ** (DEF_DOUT_WIDTH - 1)) - 1;
  localparam int DOUT_MIN = -(2 ** (DEF_DOUT_WIDTH - 1));

  // Working width of round_sat(); every supported input width (product or
  // accumulator) stays below this, so the rounding add has headroom.
  localparam int unsigned MAX_W = 64;

  typedef struct packed {
    logic             sat;
    logic [MAX_W-1:0] q;
  } round_sat_t;

  // Q = (x + 2^(shift-1)) >>> shift (or x when shift is 0), then clamp to a
  // signed dout_w-bit range; sat reports that the clamp was applied.
  function automatic round_sat_t round_sat(input logic signed [MAX_W-1:0] x,
                                           input int unsigned             dout_w,
                                           input int unsigned             shift);
    logic signed [MAX_W-1:0] rnd;
    logic signed [MAX_W-1:0] r;
    logic signed [MAX_W-1:0] max_v;
    logic signed [MAX_W-1:0] min_v;
    round_sat_t              res;
    rnd = '0;
    r   = x;
    if (shift != 0) begin
      rnd = MAX_W'(1) << (shift - 1);
      r   = (x + rnd) >>> shift;
    end
    max_v   = (MAX_W'(1) << (dout_w - 1)) - MAX_W'(1);
    min_v   = -(MAX_W'(1) << (dout_w - 1));
    res.sat = 1'b0;
    res.q   = r;
    if (r > max_v) begin
      res.sat = 1'b1;
      res.q   = max_v;
    end else if (r < min_v) begin
      res.sat = 1'b1;
      res.q   = min_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/pi_control_mul_round_sat.sv
// Combinational round-half-up scaling and saturation of the final-stage
// operand.
// Ports:
//   din_i    signed value to scale (product or accumulator), IN_WIDTH bits
//   res_c_o  rounded/saturated result, DOUT_WIDTH bits
//   sat_c_o  high when res_c_o was clamped to the min/max value
module pi_control_mul_round_sat
  import pi_control_mul_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = PROD_WIDTH,
  parameter int unsigned DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int unsigned SHIFT      = 15
) (
  input  logic [IN_WIDTH-1:0]   din_i,
  output logic [DOUT_WIDTH-1:0] res_c_o,
  output logic                  sat_c_o
);

  round_sat_t rs;
  logic       unused_hi;

  // Sign-extend into the working width before rounding.
  always_comb begin
    rs = round_sat(MAX_W'($signed(din_i)), DOUT_WIDTH, SHIFT);
  end

  assign res_c_o   = rs.q[DOUT_WIDTH-1:0];
  assign sat_c_o   = rs.sat;
  // Upper bits are only sign copies after clamping.
  assign unused_hi = ^rs.q[MAX_W-1:DOUT_WIDTH];

endmodule

// File: rtl/pi_control_mul_pipe.sv
// Pipelined signed multiplier for the PI control datapath with valid/ready
// handshake, round-half-up scaling, output saturation and a sticky
// saturation flag.
// Optional feature: define PI_CONTROL_MUL_ACC_EN to add an ACC_WIDTH
// accumulator after the product stage and the acc_first input.
// Ports:
//   ap_clk, ap_rst      clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   din0, din1          signed operands A and B
//   out_valid/out_ready result handshake
//   dout                signed rounded/saturated result
//   sat_flag, sat_clr   sticky saturation flag and its clear
//   acc_first           (feature only) restart accumulation with this product
module pi_control_mul_pipe
  import pi_control_mul_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int unsigned DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int unsigned DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int unsigned SHIFT      = 15,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat_flag,
`ifdef PI_CONTROL_MUL_ACC_EN
  input  logic                  acc_first,
`endif
  input  logic                  sat_clr
);

  localparam int unsigned PROD_W = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned ND     = NUM_STAGE - 3;
`ifdef PI_CONTROL_MUL_ACC_EN
  localparam int unsigned XW     = ACC_WIDTH;
`else
  localparam int unsigned XW     = PROD_W;
`endif

  logic                         ce_c;
  logic                         v1_q;
  logic [DIN0_WIDTH-1:0]        a_q;
  logic [DIN1_WIDTH-1:0]        b_q;
  logic                         v2_q;
  logic signed [PROD_W-1:0]     p_d;
  logic signed [PROD_W-1:0]     p_q;
  logic signed [XW-1:0]         x_s2;
  logic signed [XW-1:0]         fin_x;
  logic                         fin_v;
  logic [DOUT_WIDTH-1:0]        rs_res;
  logic                         rs_sat;
  logic                         out_valid_q, out_valid_d;
  logic [DOUT_WIDTH-1:0]        dout_q, dout_d;
  logic                         sat_flag_q, sat_flag_d;

  // Single advance enable: the whole pipe moves unless the output is blocked.
  assign ce_c     = ~out_valid_q | out_ready;
  assign in_ready = ce_c;

  // S1: operand capture.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      v1_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (ce_c) begin
      v1_q <= in_valid;
      a_q  <= din0;
      b_q  <= din1;
    end
  end

  // Full-width signed product.
  always_comb begin
    p_d = PROD_W'($signed(a_q)) * PROD_W'($signed(b_q));
  end

  // S2: product register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      v2_q <= 1'b0;
      p_q  <= '0;
    end else if (ce_c) begin
      v2_q <= v1_q;
      p_q  <= p_d;
    end
  end

`ifdef PI_CONTROL_MUL_ACC_EN
  logic                        first1_q;
  logic                        first2_q;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

  // acc_first travels alongside its operands.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      first1_q <= 1'b0;
      first2_q <= 1'b0;
    end else if (ce_c) begin
      first1_q <= acc_first;
      first2_q <= first1_q;
    end
  end

  // New accumulator value is consumed in the same advance, keeping latency.
  always_comb begin
    acc_d = first2_q ? ACC_WIDTH'(p_q) : acc_q + ACC_WIDTH'(p_q);
    x_s2  = acc_d;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_q <= '0;
    end else if (ce_c && v2_q) begin
      acc_q <= acc_d;
    end
  end
`else
  assign x_s2 = p_q;
`endif

  // Optional plain delay stages between S2 and the final stage.
  generate
    if (ND > 0) begin : g_dly
      logic signed [XW-1:0] dx_q [ND];
      logic [ND-1:0]        dv_q;

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          dv_q <= '0;
          for (int i = 0; i < ND; i++) begin
            dx_q[i] <= '0;
          end
        end else if (ce_c) begin
          dv_q[0] <= v2_q;
          dx_q[0] <= x_s2;
          for (int i = 1; i < ND; i++) begin
            dv_q[i] <= dv_q[i-1];
            dx_q[i] <= dx_q[i-1];
          end
        end
      end

      assign fin_x = dx_q[ND-1];
      assign fin_v = dv_q[ND-1];
    end else begin : g_nodly
      assign fin_x = x_s2;
      assign fin_v = v2_q;
    end
  endgenerate

  pi_control_mul_round_sat #(
    .IN_WIDTH  (XW),
    .DOUT_WIDTH(DOUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_round_sat (
    .din_i  (fin_x),
    .res_c_o(rs_res),
    .sat_c_o(rs_sat)
  );

  // Final stage next state; a set of sat_flag overrides a same-cycle clear.
  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    sat_flag_d  = sat_flag_q & ~sat_clr;
    if (ce_c) begin
      out_valid_d = fin_v;
      if (fin_v) begin
        dout_d = rs_res;
        if (rs_sat) begin
          sat_flag_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_pi_control_mul_pipe.sv
// Directed testbench for pi_control_mul_pipe at default parameters
// (16x17 -> 16, SHIFT=15, NUM_STAGE=3).
module tb_pi_control_mul_pipe;

  logic               ap_clk;
  logic               ap_rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] din0;
  logic signed [16:0] din1;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] dout;
  logic               sat_flag;
  logic               sat_clr;
  logic               acc_first;

  int n_chk;
  int n_pass;

  pi_control_mul_pipe dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din0     (din0),
    .din1     (din1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .sat_flag (sat_flag),
`ifdef PI_CONTROL_MUL_ACC_EN
    .acc_first(acc_first),
`endif
    .sat_clr  (sat_clr)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Send one operand pair into an empty pipe, wait for its result and check
  // latency, value and flag. clr raises sat_clr in the cycle the result loads.
  task automatic run_one(input string tag, input int a, input int b,
                         input int exp_q, input bit exp_flag, input bit clr);
    int cnt;
    din0     = 16'(a);
    din1     = 17'(b);
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    cnt      = 1;
    while (!out_valid && cnt < 10) begin
      if (cnt == 2) sat_clr = clr;
      @(posedge ap_clk); #1;
      cnt++;
    end
    sat_clr = 1'b0;
    check({tag, "_lat"}, cnt, 3);
    check(tag, dout, exp_q);
    check({tag, "_flag"}, sat_flag, exp_flag);
    @(posedge ap_clk); #1;
  endtask

  int a_bp[8]   = '{100, -7, 10, 11, -11, 200, 32767, 0};
  int b_bp[8]   = '{32768, 32768, 16384, 16384, 16384, -32768, 32767, 12345};
  int exp_bp[8] = '{100, -7, 5, 6, -5, -200, 32766, 0};

  initial begin
    int                 idx;
    int                 rcv;
    int                 stale;
    bit                 prev_stall;
    logic signed [15:0] prev_d;

    n_chk     = 0;
    n_pass    = 0;
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    din0      = '0;
    din1      = '0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    acc_first = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_in_ready", in_ready, 1);

    // Scaling and round-half-up.
    run_one("unity", 16384, 32768, 16384, 0, 0);
    run_one("r_1p375", 11, 4096, 1, 0, 0);
    run_one("r_3p0", 3, 32768, 3, 0, 0);
    run_one("r_1p5", 3, 16384, 2, 0, 0);
    run_one("r_m1p5", -3, 16384, -1, 0, 0);
    // Range edges that must not saturate.
    run_one("b_max", 32767, 32768, 32767, 0, 0);
    run_one("b_min", -32768, 32768, -32768, 0, 0);

    // Saturation and the sticky flag.
    run_one("s_pos", -32768, -65536, 32767, 1, 0);
    check("sat_sticky", sat_flag, 1);
    sat_clr = 1'b1;
    @(posedge ap_clk); #1;
    sat_clr = 1'b0;
    check("sat_clr", sat_flag, 0);
    run_one("s_set_wins", -32768, -32768, 32767, 1, 1);
    sat_clr = 1'b1;
    @(posedge ap_clk); #1;
    sat_clr = 1'b0;
    check("sat_clr2", sat_flag, 0);
    run_one("s_neg", -32768, 65535, -32768, 1, 0);

    // Back-pressure: out_ready low in cycles 4..7 of an 8-item stream.
    idx        = 0;
    rcv        = 0;
    prev_stall = 1'b0;
    prev_d     = '0;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 7);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        din0 = 16'(a_bp[idx]);
        din1 = 17'(b_bp[idx]);
      end
      #1;
      if (cyc >= 4 && cyc <= 7) check("bp_in_ready", in_ready, 0);
      if (prev_stall) check("bp_hold", dout, prev_d);
      prev_stall = out_valid && !out_ready;
      prev_d     = dout;
      if (out_valid && out_ready) begin
        check("bp_data", dout, exp_bp[rcv]);
        rcv++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge ap_clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", rcv, 8);
    check("bp_no_dup", out_valid, 0);

    // Reset with three items in flight.
    in_valid = 1'b1;
    din0     = -16'sd32768;
    din1     = -17'sd65536;
    @(posedge ap_clk); #1;
    din0 = 16'sd100;
    din1 = 17'sd32768;
    @(posedge ap_clk); #1;
    din0 = 16'sd5;
    din1 = 17'sd32768;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    check("mid_pre_valid", out_valid, 1);
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    check("mid_out_valid", out_valid, 0);
    check("mid_sat_flag", sat_flag, 0);
    check("mid_dout", dout, 0);
    check("mid_in_ready", in_ready, 1);
    stale = 0;
    repeat (8) begin
      @(posedge ap_clk); #1;
      if (out_valid) stale++;
    end
    check("mid_no_stale", stale, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
